// File: rtl/io_pwm.sv
// io_pwm: 3-channel double-buffered PWM on the dma_io register bus, spliced into the rdata daisy chain.
`timescale 1ns/1ps
module io_pwm #(
    parameter logic [13:0] BASE_ADR = 14'h3F10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic [2:0]  pwm_out,
    output logic        pwm_wrap_1shot
);
    logic [2:0]       en;
    logic [15:0]      top_sh, top_act, ps, pre_cnt, cnt;
    logic [2:0][15:0] duty_sh, duty_act;
    logic             flag, rd_hit;
    logic [31:0]      rd_data, rd_val;
    logic [13:0]      woff, roff;
    logic             run, tick, wrap_raw, wrap, clr, load;
    logic             unused;

    assign unused = ^dma_io_wdata[31:17];
    assign woff = dma_io_wadr - BASE_ADR;
    assign roff = dma_io_radr - BASE_ADR;
    assign clr = dma_io_we && woff == 14'd0 && dma_io_wdata[8];
    assign run = |en;
    assign tick = run && pre_cnt == ps;
    assign wrap_raw = tick && cnt == top_act;
    // a counter clear wins over a coincident wrap and suppresses its pulse
    assign wrap = wrap_raw && !clr;
    assign load = wrap || clr || !run;
    assign dma_io_rdata = rd_hit ? rd_data : dma_io_rdata_in;

    always_comb begin
        rd_val = roff == 14'd0 ? {29'd0, en} :
                 roff == 14'd1 ? {16'd0, top_sh} :
                 roff == 14'd2 ? {16'd0, ps} :
                 roff == 14'd3 ? {16'd0, duty_sh[0]} :
                 roff == 14'd4 ? {16'd0, duty_sh[1]} :
                 roff == 14'd5 ? {16'd0, duty_sh[2]} :
                 roff == 14'd6 ? {15'd0, flag, cnt} : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en             <= '0;
            top_sh         <= '0;
            top_act        <= '0;
            ps             <= '0;
            pre_cnt        <= '0;
            cnt            <= '0;
            duty_sh        <= '0;
            duty_act       <= '0;
            flag           <= 1'b0;
            rd_hit         <= 1'b0;
            rd_data        <= '0;
            pwm_out        <= '0;
            pwm_wrap_1shot <= 1'b0;
        end else begin
            if (dma_io_we && woff == 14'd0) en <= dma_io_wdata[2:0];
            if (dma_io_we && woff == 14'd1) top_sh <= dma_io_wdata[15:0];
            if (dma_io_we && woff == 14'd2) ps <= dma_io_wdata[15:0];
            if (dma_io_we && woff == 14'd3) duty_sh[0] <= dma_io_wdata[15:0];
            if (dma_io_we && woff == 14'd4) duty_sh[1] <= dma_io_wdata[15:0];
            if (dma_io_we && woff == 14'd5) duty_sh[2] <= dma_io_wdata[15:0];
            // compares are equality-only, so a limit written below the count rolls over through 16'hFFFF
            pre_cnt <= (clr || !run || tick) ? 16'd0 : pre_cnt + 16'd1;
            cnt <= (clr || !run || wrap_raw) ? 16'd0 : tick ? cnt + 16'd1 : cnt;
            if (load) begin
                top_act  <= top_sh;
                duty_act <= duty_sh;
            end
            for (int i = 0; i < 3; i++) pwm_out[i] <= en[i] && cnt < duty_act[i];
            pwm_wrap_1shot <= wrap;
            flag <= wrap || (flag && !(dma_io_we && woff == 14'd6 && dma_io_wdata[16]));
            rd_hit <= dma_io_radr_en && roff < 14'd7;
            rd_data <= rd_val;
        end
    end
endmodule

// File: tb/tb_io_pwm.sv
// tb_io_pwm: directed self-checking bench for io_pwm; inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_io_pwm;
    localparam logic [13:0] B = 14'h3F10;
    logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0, radr_en = 1'b0;
    logic [13:0] wadr = '0, radr = '0;
    logic [31:0] wdata = '0, rdata_in = 32'hdeadbeef, rdata, v;
    logic [2:0]  pwm;
    logic        wrap;
    logic [63:0] c0 = '0, c1 = '0, c2 = '0, cw = '0;
    int          ncap = 0, n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    io_pwm #(.BASE_ADR(B)) dut (
        .clk(clk), .rst_n(rst_n), .dma_io_we(we), .dma_io_wadr(wadr), .dma_io_wdata(wdata),
        .dma_io_radr(radr), .dma_io_radr_en(radr_en), .dma_io_rdata_in(rdata_in),
        .dma_io_rdata(rdata), .pwm_out(pwm), .pwm_wrap_1shot(wrap)
    );

    task automatic step();
        @(negedge clk);
        if (ncap < 64) begin
            c0[ncap] = pwm[0];
            c1[ncap] = pwm[1];
            c2[ncap] = pwm[2];
            cw[ncap] = wrap;
        end
        ncap++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [13:0] off, input logic [31:0] d);
        we = 1'b1;
        wadr = B + off;
        wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic rda(input logic [13:0] a, output logic [31:0] d);
        radr_en = 1'b1;
        radr = a;
        step();
        d = rdata;
        radr_en = 1'b0;
    endtask

    task automatic rd(input logic [13:0] off, output logic [31:0] d);
        rda(B + off, d);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_pwm", 64'(pwm), 64'h0);
        chk("rst_wrap", 64'(wrap), 64'h0);
        chk("rst_passthru", 64'(rdata), 64'hdeadbeef);
        rst_n = 1'b1;
        rd(0, v);             chk("ctrl_rst", 64'(v), 64'h0);
        rda(14'h3F20, v);     chk("unmapped", 64'(v), 64'hdeadbeef);
        rd(7, v);             chk("offset7", 64'(v), 64'hdeadbeef);
        rd(6, v);             chk("status_rst", 64'(v), 64'h0);
        we = 1'b1; wadr = B + 14'd2; wdata = 32'd7; radr_en = 1'b1; radr = B + 14'd2;
        step();
        v = rdata; we = 1'b0; radr_en = 1'b0;
        chk("rw_same_cycle", 64'(v), 64'h0);
        rd(2, v);             chk("ps_readback", 64'(v), 64'h7);
        wr(2, 32'd0);
        wr(1, 32'hABCD0009);
        rd(1, v);             chk("period_unused_bits", 64'(v), 64'h9);
        // basic period 10, duty 3
        wr(3, 32'd3);
        wr(0, 32'd1);
        ncap = 0;
        repeat (20) step();
        chk("t2_pwm0", 64'(c0[19:0]), 64'h01C07);
        chk("t2_pwm1", 64'(c1[19:0]), 64'h0);
        chk("t2_wrap", 64'(cw[19:0]), 64'h80200);
        rd(6, v);             chk("t2_status", 64'(v), 64'h10000);
        // counter clear on a wrap edge: no pulse, count restarts
        repeat (8) step();
        wr(0, 32'h101);
        chk("clr_no_wrap", 64'(wrap), 64'h0);
        rd(6, v);             chk("clr_cnt0", 64'(v), 64'h10000);
        rd(6, v);             chk("clr_cnt1", 64'(v), 64'h10001);
        rd(0, v);             chk("clr_reads0", 64'(v), 64'h1);
        // prescale 1
        wr(0, 32'd0);
        wr(6, 32'h10000);
        rd(6, v);             chk("t3_flag_clear", 64'(v), 64'h0);
        wr(2, 32'd1);
        wr(0, 32'd1);
        ncap = 0;
        repeat (20) step();
        chk("t3_pwm0", 64'(c0[19:0]), 64'h0003F);
        chk("t3_wrap", 64'(cw[19:0]), 64'h80000);
        rd(6, v);             chk("t3_cnt_a", 64'(v), 64'h10000);
        rd(6, v);             chk("t3_cnt_b", 64'(v), 64'h10000);
        rd(6, v);             chk("t3_cnt_c", 64'(v), 64'h10001);
        rd(6, v);             chk("t3_cnt_d", 64'(v), 64'h10001);
        // duty boundaries
        wr(0, 32'd0);
        wr(2, 32'd0);
        wr(4, 32'd0);
        wr(5, 32'd10);
        wr(0, 32'd7);
        ncap = 0;
        repeat (20) step();
        chk("t4_pwm0", 64'(c0[19:0]), 64'h01C07);
        chk("t4_duty0", 64'(c1[19:0]), 64'h0);
        chk("t4_duty_gt_top", 64'(c2[19:0]), 64'hFFFFF);
        // double buffering of duty
        wr(0, 32'd0);
        wr(0, 32'd1);
        ncap = 0;
        repeat (5) step();
        wr(3, 32'd5);
        repeat (34) step();
        chk("t5_mid_period", 64'(c0[39:0]), 64'h7C1F07C07);
        ncap = 0;
        repeat (9) step();
        wr(3, 32'd2);
        repeat (20) step();
        chk("t5_wrap_write", 64'(c0[29:0]), 64'h307C1F);
        chk("t5_wrap", 64'(cw[29:0]), 64'h20080200);
        // sticky flag: set wins over a clear on the wrap edge
        repeat (9) step();
        wr(6, 32'h10000);
        chk("t6_wrap_pulse", 64'(wrap), 64'h1);
        rd(6, v);             chk("t6_set_wins", 64'(v), 64'h10000);
        wr(6, 32'h10000);
        rd(6, v);             chk("t6_cleared", 64'(v), 64'h2);
        // reset mid-period
        repeat (8) step();
        chk("t6_pre_rst_pwm", 64'(pwm), 64'h1);
        rst_n = 1'b0;
        step();
        chk("t6_rst_pwm", 64'(pwm), 64'h0);
        chk("t6_rst_wrap", 64'(wrap), 64'h0);
        chk("t6_rst_rdata", 64'(rdata), 64'hdeadbeef);
        rst_n = 1'b1;
        rd(6, v);             chk("t6_rst_status", 64'(v), 64'h0);
        rd(0, v);             chk("t6_rst_ctrl", 64'(v), 64'h0);
        rd(3, v);             chk("t6_rst_duty0", 64'(v), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/io_pwm.md
Name: io_pwm

Overview:
- 3-channel PWM peripheral on the shared dma_io register bus, inserted into the rdata daisy chain: its rdata_in is fed by one IO stage and its rdata output feeds the next stage.
- Intended use: dimming of rgb_led channels.
- Provides a per-period wrap pulse that can be routed to the interrupter.

Parameters:
- BASE_ADR, 14'h3F10: word address (bits 15:2) of register offset 0. The block decodes BASE_ADR+0 .. BASE_ADR+6.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- dma_io_we  in  1  register write strobe
- dma_io_wadr  in  14 [15:2]  write word address
- dma_io_wdata  in  32  write data
- dma_io_radr  in  14 [15:2]  read word address
- dma_io_radr_en  in  1  read strobe
- dma_io_rdata_in  in  32  read data from the upstream chain stage
- dma_io_rdata  out  32  read data to the downstream chain stage
- pwm_out  out  3  PWM outputs, active-high
- pwm_wrap_1shot  out  1  one-cycle pulse at each period wrap

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.

Register map (offset from BASE_ADR):
- +0 CTRL: [2:0] channel enable, RW. [8] counter clear, write-1, self-clearing, reads 0.
- +1 PERIOD: [15:0] TOP, RW. Period = TOP+1 counts.
- +2 PRESCALE: [15:0] PS, RW. Counter advances every PS+1 clocks.
- +3/+4/+5 DUTY0/1/2: [15:0], RW.
- +6 STATUS: [15:0] current count, RO. [16] wrap sticky flag, write-1-to-clear.
- Unused bits read 0. Writes to unmapped offsets are ignored.

Reset:
- All registers, shadows, counters, STATUS flag and pwm_out = 0.
- pwm_wrap_1shot = 0.
- Internal read-hit flag = 0, so dma_io_rdata = dma_io_rdata_in.

Read timing:
- Read issued when dma_io_radr_en=1 at cycle N.
- At N+1: if the address hit, dma_io_rdata = registered register value; otherwise dma_io_rdata = dma_io_rdata_in (combinational pass-through).
- A read and a write to the same register in the same cycle returns the pre-write value.

Counting:
- run = |CTRL[2:0].
- pre_cnt counts 0..PS. tick = run & (pre_cnt == PS).
- cnt increments on tick. On tick with cnt == TOP_act: cnt <= 0, pre_cnt <= 0, wrap event.
- When run = 0: pre_cnt and cnt are held at 0.
- Counter clear (CTRL[8] write): cnt <= 0, pre_cnt <= 0 next cycle, active registers reload from shadows. No wrap pulse.
- PS or TOP written below the current counter value: counter runs to 16'hFFFF, wraps to 0, then normal compare resumes. No lockup.

Double buffering:
- PERIOD and DUTYx writes go to shadow registers.
- Active copies (TOP_act, DUTY_act) load from shadows on a wrap event, on counter clear, or every cycle while run = 0.
- A shadow write in the same cycle as a wrap takes effect at the following wrap.

Outputs:
- pwm_out[i] <= CTRL[i] & (cnt < DUTY_act[i]), registered, 1-cycle lag behind cnt.
- DUTY = 0 gives constant 0. DUTY > TOP gives constant 1.
- Disabled channel gives 0.
- pwm_wrap_1shot = 1 for exactly the cycle after a wrap event.

STATUS[16]:
- Set by a wrap event. Cleared by writing 1.
- Simultaneous set and clear: set wins.

Mid-operation reset:
- rst_n low for any cycle restores every reset value on the next edge.
- No partial period or pulse survives.

Test Plan:
1. Reset then read CTRL -> 0x00000000. Read unmapped 0xFC80 -> upstream value 0xdeadbeef. pwm_out = 3'b000.
2. PERIOD=9, PS=0, DUTY0=3, CTRL=1 -> pwm_out[0] high 3 clks, low 7, period 10. pwm_wrap_1shot every 10 clks. STATUS[16] = 1.
3. Same setup with PS=1 -> period 20 clks, high time 6 clks. STATUS[15:0] reads advance once per 2 clks.
4. DUTY1=0, DUTY2=10, TOP=9, CTRL=7 -> pwm_out[1] constant 0, pwm_out[2] constant 1.
5. DUTY0 changed 3 -> 5 at count 5 -> current period high 3, next period high 5. Write on the wrap cycle -> applies one period later.
6. Write STATUS=0x10000 in the wrap cycle -> flag stays 1. Write later -> flag 0. rst_n low mid-period -> pwm_out=0, cnt=0 next cycle.
